player_input_conditioner: RTL and testbench
===========================================

# player_input_conditioner

Conditions the four raw direction buttons into the `switch_*` commands consumed by `player_position_controller`. Each button is synchronised and debounced, then remapped into the gravity-relative frame selected by `gravity_direction`, so `switch_up` always means "jump away from the floor". The block also emits a single-cycle jump pulse and locks all commands out for a short window after every gravity change, so a held button cannot carry a stale meaning into the new frame. It sits directly upstream of `player_position_controller` and shares its clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 3: consecutive stable cycles needed to accept a button level change. Legal range 1..255.
- `LOCKOUT_CYCLES`, default 8: cycles all outputs are held at 0 after a gravity change. Legal range 1..255.

Ports:
- `clk_player_control`  in  1  single clock; same domain as the position controller.
- `reset`  in  1  asynchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous, bouncing button levels.
- `gravity_direction`  in  3  0 none, 1 up, 2 right, 3 down, 4 left; codes 5–7 behave as 0.
- `switch_up`, `switch_down`, `switch_left`, `switch_right`  out  1 each  registered, gravity-relative commands.
- `jump_pulse`  out  1  registered; high for one cycle on each rising edge of `switch_up`.
- `input_locked`  out  1  registered; high while state is not NORMAL.

## Operation
- **Reset values.** All outputs are 0. Synchroniser flops, debounced states and debounce counters are 0. `grav_q` is 0. State is WAIT_RELEASE.
- **Synchroniser.** Two flops per button, giving `s2`.
- **Debounce.** Per-button counter `cnt` (8-bit).
  - If `s2` equals the debounced state `db`, `cnt` is set to 0.
  - Otherwise `cnt` increments. When it would reach `DEBOUNCE_CYCLES`, `db` toggles and `cnt` is set to 0.
  - A single cycle of agreement with `db` restarts the count.
- **Remap.** The mapping uses `grav_q`, not the raw `gravity_direction` input. Listed as up / down / left / right:
  - 0, 3, 5–7: `db_up` / `db_down` / `db_left` / `db_right`.
  - 1: `db_down` / `db_up` / `db_left` / `db_right`.
  - 2: `db_left` / `db_right` / `db_up` / `db_down`.
  - 4: `db_right` / `db_left` / `db_down` / `db_up`.
- **FSM.** Three states: NORMAL, LOCKOUT, WAIT_RELEASE.
  - Any state, when `gravity_direction != grav_q`: go to LOCKOUT, load `lock_cnt` with `LOCKOUT_CYCLES-1`, and update `grav_q`. This has priority over every other transition and restarts an in-progress lockout.
  - LOCKOUT: `lock_cnt` decrements. When `lock_cnt == 0`, go to WAIT_RELEASE.
  - WAIT_RELEASE: when all four `db` are 0, go to NORMAL. Otherwise stay.
  - NORMAL: stay.
- **Output registers.**
  - Each `switch_*` is loaded with `(state == NORMAL) ? remapped : 0`.
  - `jump_pulse` is loaded with `next_switch_up & ~switch_up`.
  - `input_locked` is loaded with `(state != NORMAL)`.
  - Outputs reflect the state and `grav_q` held before the current edge.

## Timing
- **Button latency.** Call edge 1 the first rising edge that samples a new raw level, with the level stable from then on. `db` toggles at edge `DEBOUNCE_CYCLES+2`. The output register reflects the change at edge `DEBOUNCE_CYCLES+3`.
- **Jump pulse.** `jump_pulse` is high in the same cycle that `switch_up` first reads 1, for exactly one cycle.
- **Gravity change at edge g.**
  - Outputs may show the old mapping at edge g. They are 0 from edge g+1.
  - `input_locked` is 1 from edge g+1.
  - The FSM enters WAIT_RELEASE at edge g+`LOCKOUT_CYCLES`.
  - With no buttons held, it reaches NORMAL at edge g+`LOCKOUT_CYCLES`+1, and remapped outputs resume at edge g+`LOCKOUT_CYCLES`+2.
- **After reset.**
  - If `gravity_direction` is 0 and no button is held, the block reaches NORMAL on the first edge after reset deasserts.
  - If `gravity_direction` is non-zero, it enters a full lockout first.
- **Reset mid-operation.** Asynchronous reset clears everything immediately, including any counter that is mid-count.

## Structure
- Package `player_input_pkg` holds:
  - gravity code constants `GRAV_NONE`, `GRAV_UP`, `GRAV_RIGHT`, `GRAV_DOWN`, `GRAV_LEFT`;
  - FSM state encodings `ST_NORMAL`, `ST_LOCKOUT`, `ST_WAIT_RELEASE` (2-bit).
- Sub-module `button_debouncer`, instantiated four times.
  - Contains the 2-flop synchroniser, the counter and `db`.
  - Parameter: `DEBOUNCE_CYCLES`. Ports: `clk_player_control`, `reset`, `btn_raw`, `btn_db`.
- The top level contains the remap mux, FSM, lockout counter and output registers.

## Test plan
- **Clean press.** Defaults; gravity 0; hold `btn_up` from edge 1 → `switch_up` = 1 at edge 6, `jump_pulse` = 1 only at edge 6.
- **Bounce rejection.** `btn_left` toggles every 2 cycles for 20 cycles, then stays 1 → `switch_left` stays 0 until 6 edges after the final stable level is first sampled.
- **Remap.** Gravity 4 with lockout completed; hold `btn_right` → `switch_up` = 1, all other `switch_*` = 0. Switch to gravity 2 and hold `btn_up` → `switch_left` = 1.
- **Lockout with held button.** NORMAL, gravity 3, `btn_up` held; set gravity to 1 at edge g → all outputs 0 from g+1, `input_locked` = 1. After `btn_up` is released, outputs resume 2 edges after WAIT_RELEASE sees all `db` = 0.
- **Lockout restart.** Change gravity at g, then again at g+4 → lockout ends at g+4+8; `grav_q` holds the second code.
- **Reset mid-lockout.** Assert `reset` asynchronously mid-LOCKOUT → all outputs 0 immediately. With gravity 0 and no buttons held, `input_locked` = 0 two edges after reset deasserts.

Source files
------------

// File: rtl/player_input_pkg.sv
// Shared gravity codes, FSM states and direction bundle for the
// player input conditioning path.
package player_input_pkg;

  localparam logic [2:0] GRAV_NONE  = 3'd0;
  localparam logic [2:0] GRAV_UP    = 3'd1;
  localparam logic [2:0] GRAV_RIGHT = 3'd2;
  localparam logic [2:0] GRAV_DOWN  = 3'd3;
  localparam logic [2:0] GRAV_LEFT  = 3'd4;

  typedef enum logic [1:0] {
    ST_NORMAL       = 2'd0,
    ST_LOCKOUT      = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } pic_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Rotate the debounced buttons into the gravity-relative frame.
  function automatic dir_t remap_dir(
    input dir_t       d,
    input logic [2:0] g
  );
    dir_t r;
    r = d;
    unique case (1'b1)
      (g == GRAV_UP): begin
        r.up    = d.down;
        r.down  = d.up;
        r.left  = d.left;
        r.right = d.right;
      end
      (g == GRAV_RIGHT): begin
        r.up    = d.left;
        r.down  = d.right;
        r.left  = d.up;
        r.right = d.down;
      end
      (g == GRAV_LEFT): begin
        r.up    = d.right;
        r.down  = d.left;
        r.left  = d.down;
        r.right = d.up;
      end
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/player_input_conditioner_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for
// one raw button line.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic clk_player_control,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic [7:0] cnt;

  always_ff @(posedge clk_player_control or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        btn_db <= ~btn_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/player_input_conditioner.sv
// Debounces the direction buttons, remaps them into the gravity frame
// and gates them through a post-gravity-change lockout.
module player_input_conditioner
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 8
) (
  input  logic       clk_player_control,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [2:0] gravity_direction,
  output logic       switch_up,
  output logic       switch_down,
  output logic       switch_left,
  output logic       switch_right,
  output logic       jump_pulse,
  output logic       input_locked
);

  localparam logic [7:0] LOCK_INIT = 8'(LOCKOUT_CYCLES - 1);

  dir_t       db;
  dir_t       rem;
  dir_t       nxt;
  pic_state_t state;
  logic [2:0] grav_q;
  logic [7:0] lock_cnt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_player_control(clk_player_control),
    .reset(reset),
    .btn_raw(btn_up),
    .btn_db(db.up)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk_player_control(clk_player_control),
    .reset(reset),
    .btn_raw(btn_down),
    .btn_db(db.down)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk_player_control(clk_player_control),
    .reset(reset),
    .btn_raw(btn_left),
    .btn_db(db.left)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk_player_control(clk_player_control),
    .reset(reset),
    .btn_raw(btn_right),
    .btn_db(db.right)
  );

  assign rem = remap_dir(db, grav_q);
  assign nxt = (state == ST_NORMAL) ? rem : '0;

  always_ff @(posedge clk_player_control or posedge reset) begin
    if (reset) begin
      state        <= ST_WAIT_RELEASE;
      grav_q       <= GRAV_NONE;
      lock_cnt     <= '0;
      switch_up    <= 1'b0;
      switch_down  <= 1'b0;
      switch_left  <= 1'b0;
      switch_right <= 1'b0;
      jump_pulse   <= 1'b0;
      input_locked <= 1'b0;
    end else begin
      switch_up    <= nxt.up;
      switch_down  <= nxt.down;
      switch_left  <= nxt.left;
      switch_right <= nxt.right;
      jump_pulse   <= nxt.up & ~switch_up;
      input_locked <= (state != ST_NORMAL);
      // A new gravity code always restarts the full lockout window.
      if (gravity_direction != grav_q) begin
        state    <= ST_LOCKOUT;
        lock_cnt <= LOCK_INIT;
        grav_q   <= gravity_direction;
      end else begin
        unique case (state)
          ST_LOCKOUT: begin
            if (lock_cnt == 8'd0) begin
              state <= ST_WAIT_RELEASE;
            end else begin
              lock_cnt <= lock_cnt - 8'd1;
            end
          end
          ST_WAIT_RELEASE: begin
            if (db == '0) begin
              state <= ST_NORMAL;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Randomised scoreboard bench for player_input_conditioner against a
// window/edge-count reference model.
module tb_player_input_conditioner;

  localparam int DB = 3;
  localparam int LK = 8;

  typedef struct packed {
    logic [3:0] sw;
    logic       jp;
    logic       lk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0;
  logic [2:0] grav = 3'd0;
  logic       switch_up;
  logic       switch_down;
  logic       switch_left;
  logic       switch_right;
  logic       jump_pulse;
  logic       input_locked;

  int checks = 0;
  int failures = 0;

  exp_t q[$];

  int         n;
  bit         m_normal;
  bit         m_inlock;
  int         m_lockend;
  logic [2:0] m_gq;
  logic [3:0] m_db;
  bit         prev_up;
  bit         hist[4][$];

  always #5 clk = ~clk;

  player_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LOCKOUT_CYCLES(LK)
  ) dut (
    .clk_player_control(clk),
    .reset(reset),
    .btn_up(btn[3]),
    .btn_down(btn[2]),
    .btn_left(btn[1]),
    .btn_right(btn[0]),
    .gravity_direction(grav),
    .switch_up(switch_up),
    .switch_down(switch_down),
    .switch_left(switch_left),
    .switch_right(switch_right),
    .jump_pulse(jump_pulse),
    .input_locked(input_locked)
  );

  function automatic bit samp(int b, int k);
    if (k < 1) return 1'b0;
    return hist[b][k-1];
  endfunction

  // bits: [3]=up [2]=down [1]=left [0]=right
  function automatic logic [3:0] remap_ref(logic [3:0] d, logic [2:0] g);
    case (g)
      3'd1:    return {d[2], d[3], d[1], d[0]};
      3'd2:    return {d[1], d[0], d[3], d[2]};
      3'd4:    return {d[0], d[1], d[2], d[3]};
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    m_normal = 1'b0;
    m_inlock = 1'b0;
    m_lockend = 0;
    m_gq = 3'd0;
    m_db = 4'b0;
    prev_up = 1'b0;
    for (int b = 0; b < 4; b++) hist[b].delete();
  endtask

  // Predict the outputs after the coming edge, then advance the model.
  task automatic model_step();
    exp_t       e;
    logic [3:0] dv;
    bit         tog;
    n++;
    dv = m_db;
    e.sw = m_normal ? remap_ref(dv, m_gq) : 4'b0;
    e.jp = e.sw[3] & ~prev_up;
    e.lk = ~m_normal;
    prev_up = e.sw[3];
    q.push_back(e);
    if (grav != m_gq) begin
      m_inlock = 1'b1;
      m_normal = 1'b0;
      m_lockend = n + LK;
      m_gq = grav;
    end else if (m_inlock) begin
      if (n == m_lockend) m_inlock = 1'b0;
    end else if (!m_normal && dv == 4'b0) begin
      m_normal = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      tog = 1'b1;
      for (int k = n - 1 - DB; k <= n - 2; k++)
        if (samp(b, k) == m_db[b]) tog = 1'b0;
      if (tog) m_db[b] = ~m_db[b];
      hist[b].push_back(btn[b]);
    end
  endtask

  task automatic drive_edge(logic [3:0] b, logic [2:0] g);
    @(negedge clk);
    if (reset) begin
      reset = 1'b0;
      model_reset();
    end
    btn = b;
    grav = g;
    model_step();
  endtask

  task automatic dchk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {switch_up, switch_down, switch_left, switch_right,
             jump_pulse, input_locked};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs got=%b want=%b t=%0t", a, e, $time);
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] b;
    logic [2:0] g;
    model_reset();
    #1;
    dchk("reset_locked", input_locked, 1'b0);
    dchk("reset_up", switch_up, 1'b0);

    // clean press of up with gravity none
    for (int k = 1; k <= 8; k++) begin
      drive_edge(4'b1000, 3'd0);
      @(posedge clk);
      #2;
      dchk("press_up", switch_up, k >= 6);
      dchk("press_jump", jump_pulse, k == 6);
    end
    for (int k = 0; k < 10; k++) drive_edge(4'b0000, 3'd0);

    // bouncing left line, then held
    for (int k = 0; k < 20; k++) drive_edge({2'b00, k[1], 1'b0}, 3'd0);
    for (int k = 0; k < 10; k++) drive_edge(4'b0010, 3'd0);
    for (int k = 0; k < 8; k++) drive_edge(4'b0000, 3'd0);

    // gravity left, hold right -> up; then gravity right, hold up -> left
    for (int k = 0; k < 16; k++) drive_edge(4'b0000, 3'd4);
    for (int k = 0; k < 8; k++) drive_edge(4'b0001, 3'd4);
    dchk("remap_l_up", switch_up, 1'b1);
    dchk("remap_l_right", switch_right, 1'b0);
    for (int k = 0; k < 16; k++) drive_edge(4'b0000, 3'd2);
    for (int k = 0; k < 8; k++) drive_edge(4'b1000, 3'd2);
    dchk("remap_r_left", switch_left, 1'b1);

    // held button across a gravity change, then lockout restart
    for (int k = 0; k < 16; k++) drive_edge(4'b1000, 3'd3);
    for (int k = 0; k < 12; k++) drive_edge(4'b1000, 3'd1);
    for (int k = 0; k < 10; k++) drive_edge(4'b0000, 3'd1);
    for (int k = 0; k < 4; k++) drive_edge(4'b0000, 3'd6);
    for (int k = 0; k < 14; k++) drive_edge(4'b0000, 3'd2);

    // random traffic
    b = 4'b0;
    g = 3'd0;
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) begin
          if ($urandom_range(5) == 0) b[k] = 1'b0;
        end else if ($urandom_range(19) == 0) begin
          b[k] = 1'b1;
        end
      end
      if ((i % 250) >= 220) b = 4'b0;
      if ($urandom_range(39) == 0) g = 3'($urandom_range(7));
      drive_edge(b, g);
    end

    // asynchronous reset in the middle of a lockout
    for (int k = 0; k < 3; k++) drive_edge(4'b0000, 3'd5);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({switch_up, switch_down, switch_left, switch_right,
         jump_pulse, input_locked} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset outputs not cleared t=%0t", $time);
    end
    repeat (2) @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      drive_edge(4'b0000, 3'd0);
      @(posedge clk);
      #2;
      dchk("post_reset_locked", input_locked, k == 1);
    end

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
